// File: rtl/ifu_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// Widths, PC step and FSM state encoding.
package ifu_pkg;

  localparam int          ADDR_W   = 32;
  localparam int          INSTR_W  = 32;
  localparam int          PC_STEP  = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef enum logic {
    IDLE,
    FETCH
  } state_t;

endpackage

// File: rtl/ifu_fifo.sv
// Prefetch FIFO of {pc, instruction} pairs toward decode.
// Power-of-two depth; flush wins over push and pop.
module ifu_fifo #(
  parameter int DEPTH = 2,
  parameter int AW    = 32,
  parameter int IW    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [AW-1:0]              push_pc,
  input  logic [IW-1:0]              push_instr,
  output logic [AW-1:0]              head_pc,
  output logic [IW-1:0]              head_instr,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] pc_mem  [DEPTH];
  logic [IW-1:0] ins_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_pop;

  assign do_pop     = pop && (count != '0);
  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = ins_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]  <= '0;
        ins_mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]  <= push_pc;
        ins_mem[wr_ptr] <= push_instr;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count
             + {{PW{1'b0}}, push}
             - {{PW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC, one-cycle memory request/capture,
// prefetch buffering toward decode, redirect with flush.
module instruction_fetch_unit #(
  parameter int                ADDR_W   = ifu_pkg::ADDR_W,
  parameter int                INSTR_W  = ifu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ifu_pkg::RESET_PC,
  parameter int                DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  read_address,
  input  logic [INSTR_W-1:0] instruction_in,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc
);

  import ifu_pkg::*;

  localparam int PW = $clog2(DEPTH);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] inflight_pc_q;
  logic              inflight_q;
  logic [PW:0]       count;
  logic [PW+1:0]     occ;
  logic [PW+1:0]     lim;
  logic              pop;
  logic              push;
  logic              credit;
  logic              issue;
  logic [ADDR_W-1:0] target;

  assign read_address = pc_q;
  assign instr_valid  = (count != '0);
  assign pop          = instr_valid && instr_ready;
  assign push         = inflight_q && !redirect_valid;
  assign target       = redirect_pc & ~ADDR_W'(3);

  // Occupancy counts the in-flight slot so a response always has room.
  assign occ    = {1'b0, count} + {{(PW+1){1'b0}}, inflight_q};
  assign lim    = (PW+2)'(DEPTH) + {{(PW+1){1'b0}}, pop};
  assign credit = occ < lim;

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fetch_en && credit) begin
          state_d = FETCH;
          issue   = !redirect_valid;
        end
      end
      FETCH: begin
        if (!fetch_en || !credit) begin
          state_d = IDLE;
        end else begin
          issue = !redirect_valid;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q <= state_d;
      if (redirect_valid) begin
        pc_q       <= target;
        inflight_q <= 1'b0;
      end else begin
        inflight_q <= issue;
        if (issue) begin
          pc_q          <= pc_q + ADDR_W'(PC_STEP);
          inflight_pc_q <= pc_q;
        end
      end
    end
  end

  ifu_fifo #(
    .DEPTH (DEPTH),
    .AW    (ADDR_W),
    .IW    (INSTR_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_valid),
    .push_pc    (inflight_pc_q),
    .push_instr (instruction_in),
    .head_pc    (instr_pc),
    .head_instr (instr_out),
    .count      (count)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit.
// Memory model returns addr ^ 32'hA5A5_0000 one cycle after the address.
module tb_instruction_fetch_unit;

  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst, fetch_en, redirect_valid, instr_ready;
  logic [31:0] redirect_pc;
  logic [31:0] read_address, instruction_in, instr_out, instr_pc;
  logic        instr_valid;

  logic        rst2, fetch_en2;
  logic [31:0] read_address2, instruction_in2, instr_out2, instr_pc2;
  logic        instr_valid2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    instruction_in  <= read_address ^ K;
    instruction_in2 <= read_address2 ^ K;
  end

  instruction_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .read_address   (read_address),
    .instruction_in (instruction_in),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk            (clk),
    .rst            (rst2),
    .fetch_en       (fetch_en2),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .read_address   (read_address2),
    .instruction_in (instruction_in2),
    .instr_valid    (instr_valid2),
    .instr_ready    (1'b1),
    .instr_out      (instr_out2),
    .instr_pc       (instr_pc2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 0; rst2 = 0; fetch_en = 0; fetch_en2 = 0;
    redirect_valid = 0; redirect_pc = 0; instr_ready = 0;
    step(); step();
    tests++;
    if (read_address !== 32'h0) begin
      fails++; $display("FAIL reset_addr got %h exp %h", read_address, 32'h0);
    end
    tests++;
    if (instr_valid !== 1'b0) begin
      fails++; $display("FAIL reset_valid got %b exp 0", instr_valid);
    end
    tests++;
    if (instr_out !== 32'h0 || instr_pc !== 32'h0) begin
      fails++; $display("FAIL reset_head got %h/%h exp 0/0", instr_out, instr_pc);
    end
    tests++;
    if (read_address2 !== 32'hFFFF_FFF8 || instr_valid2 !== 1'b0) begin
      fails++; $display("FAIL reset_dut2 got %h/%b exp fffffff8/0", read_address2, instr_valid2);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp;
    rst2 = 1; fetch_en2 = 1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step();
      exp = 32'hFFFF_FFF8 + 32'(4 * k);
      tests++;
      if (read_address2 !== exp) begin
        fails++; $display("FAIL wrap_addr k=%0d got %h exp %h", k, read_address2, exp);
      end
      if (k >= 2) begin
        tests++;
        if (instr_valid2 !== 1'b1 || instr_pc2 !== exp - 32'd8 || instr_out2 !== ((exp - 32'd8) ^ K)) begin
          fails++; $display("FAIL wrap_head k=%0d got %b %h %h exp 1 %h %h", k, instr_valid2, instr_pc2, instr_out2, exp - 32'd8, (exp - 32'd8) ^ K);
        end
      end
    end
    fetch_en2 = 0;
  endtask

  task automatic test_stream();
    logic [31:0] p;
    rst = 1; fetch_en = 1; instr_ready = 1;
    tests++;
    if (read_address !== 32'h0) begin
      fails++; $display("FAIL stream_first got %h exp 0", read_address);
    end
    for (int k = 1; k <= 6; k++) begin
      step();
      tests++;
      if (read_address !== 32'(4 * k)) begin
        fails++; $display("FAIL stream_addr k=%0d got %h exp %h", k, read_address, 32'(4 * k));
      end
      if (k == 1) begin
        tests++;
        if (instr_valid !== 1'b0) begin
          fails++; $display("FAIL stream_early_valid got %b exp 0", instr_valid);
        end
      end else begin
        p = 32'(4 * (k - 2));
        tests++;
        if (instr_valid !== 1'b1 || instr_pc !== p || instr_out !== (p ^ K)) begin
          fails++; $display("FAIL stream_head k=%0d got %b %h %h exp 1 %h %h", k, instr_valid, instr_pc, instr_out, p, p ^ K);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] p;
    instr_ready = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      tests++;
      if (read_address !== 32'd24 || instr_valid !== 1'b1 || instr_pc !== 32'd16 || instr_out !== (32'd16 ^ K)) begin
        fails++; $display("FAIL stall i=%0d got %h %b %h %h exp 18 1 10 %h", i, read_address, instr_valid, instr_pc, instr_out, 32'd16 ^ K);
      end
    end
    instr_ready = 1;
    for (int j = 0; j < 5; j++) begin
      step();
      p = 32'(20 + 4 * j);
      tests++;
      if (instr_valid !== 1'b1 || instr_pc !== p || instr_out !== (p ^ K)) begin
        fails++; $display("FAIL resume j=%0d got %b %h %h exp 1 %h %h", j, instr_valid, instr_pc, instr_out, p, p ^ K);
      end
    end
  endtask

  task automatic test_redirect();
    redirect_valid = 1; redirect_pc = 32'h0000_0103;
    step();
    redirect_valid = 0; redirect_pc = 0;
    tests++;
    if (instr_valid !== 1'b0 || read_address !== 32'h100) begin
      fails++; $display("FAIL redir_n1 got %b %h exp 0 100", instr_valid, read_address);
    end
    step();
    tests++;
    if (instr_valid !== 1'b0 || read_address !== 32'h104) begin
      fails++; $display("FAIL redir_n2 got %b %h exp 0 104", instr_valid, read_address);
    end
    step();
    tests++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr_out !== (32'h100 ^ K)) begin
      fails++; $display("FAIL redir_n3 got %b %h %h exp 1 100 %h", instr_valid, instr_pc, instr_out, 32'h100 ^ K);
    end
  endtask

  task automatic test_fetch_en();
    fetch_en = 0;
    step();
    tests++;
    if (read_address !== 32'h108 || instr_valid !== 1'b1 || instr_pc !== 32'h104) begin
      fails++; $display("FAIL fen_inflight got %h %b %h exp 108 1 104", read_address, instr_valid, instr_pc);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      tests++;
      if (read_address !== 32'h108 || instr_valid !== 1'b0) begin
        fails++; $display("FAIL fen_hold i=%0d got %h %b exp 108 0", i, read_address, instr_valid);
      end
    end
    fetch_en = 1;
    step();
    tests++;
    if (read_address !== 32'h10C || instr_valid !== 1'b0) begin
      fails++; $display("FAIL fen_resume got %h %b exp 10c 0", read_address, instr_valid);
    end
    step();
    tests++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h108 || instr_out !== (32'h108 ^ K)) begin
      fails++; $display("FAIL fen_next got %b %h %h exp 1 108 %h", instr_valid, instr_pc, instr_out, 32'h108 ^ K);
    end
  endtask

  task automatic test_reset_mid();
    step();
    #1 rst = 0;
    #1;
    tests++;
    if (instr_valid !== 1'b0 || read_address !== 32'h0 || instr_pc !== 32'h0 || instr_out !== 32'h0) begin
      fails++; $display("FAIL rst_async got %b %h %h %h exp 0 0 0 0", instr_valid, read_address, instr_pc, instr_out);
    end
    step();
    fetch_en = 0;
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      tests++;
      if (instr_valid !== 1'b0 || read_address !== 32'h0) begin
        fails++; $display("FAIL rst_stale i=%0d got %b %h exp 0 0", i, instr_valid, read_address);
      end
    end
    fetch_en = 1;
    step();
    tests++;
    if (instr_valid !== 1'b0 || read_address !== 32'h4) begin
      fails++; $display("FAIL rst_reissue got %b %h exp 0 4", instr_valid, read_address);
    end
    step();
    tests++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_out !== K) begin
      fails++; $display("FAIL rst_first got %b %h %h exp 1 0 %h", instr_valid, instr_pc, instr_out, K);
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_stream();
    test_stall();
    test_redirect();
    test_fetch_en();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
